// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } mem_size_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_RSP,
    DONE
  } lsu_state_e;

  typedef enum logic [1:0] {
    FC_NONE     = 2'b00,
    FC_MISALIGN = 2'b01,
    FC_TIMEOUT  = 2'b10,
    FC_ILLEGAL  = 2'b11
  } fault_cause_e;

  // Access size encoded in funct3[1:0]; 2'b11 is never legal.
  function automatic mem_size_e f3_size(logic [2:0] funct3);
    case (funct3[1:0])
      2'b01:   return HALF;
      2'b10:   return WORD;
      default: return BYTE;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational store-lane formatting, load extraction and access checks.
module lsu_align
  import lsu_pkg::*;
(
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext,
  output logic        misaligned,
  output logic        illegal
);

  mem_size_e   size;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign size     = f3_size(funct3);
  assign byte_sel = rdata[{addr_lo, 3'b000} +: 8];
  assign half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

  // Legality and alignment; illegal is evaluated independently so the caller can prioritise it.
  always_comb begin
    if (we) begin
      illegal = funct3[2] | (funct3[1:0] == 2'b11);
    end else begin
      illegal = (funct3 == 3'b011) | (funct3 == 3'b110) | (funct3 == 3'b111);
    end
    misaligned = ((size == HALF) && addr_lo[0]) || ((size == WORD) && (addr_lo != 2'b00));
  end

  // Store strobes and lane replication; reads never assert strobes.
  always_comb begin
    wstrb     = 4'b0000;
    wdata_rep = wdata;
    if (we) begin
      case (size)
        BYTE: begin
          wstrb     = 4'b0001 << addr_lo;
          wdata_rep = {4{wdata[7:0]}};
        end
        HALF: begin
          wstrb     = addr_lo[1] ? 4'b1100 : 4'b0011;
          wdata_rep = {2{wdata[15:0]}};
        end
        default: begin
          wstrb     = 4'b1111;
          wdata_rep = wdata;
        end
      endcase
    end
  end

  // Load lane select plus sign/zero extension (funct3[2] selects unsigned).
  always_comb begin
    case (size)
      BYTE:    rdata_ext = funct3[2] ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      HALF:    rdata_ext = funct3[2] ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: rdata_ext = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: core-side stall/complete handshake and word-wide valid/ready bus master.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              mem_valid,
  input  logic              mem_we,
  input  logic [2:0]        mem_funct3,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic              mem_stall,
  output logic              mem_done,
  output logic [31:0]       mem_rdata,
  output logic              mem_fault,
  output logic [1:0]        mem_fault_cause,
  output logic              bus_req_valid,
  input  logic              bus_req_ready,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_we,
  output logic [3:0]        bus_wstrb,
  output logic [31:0]       bus_wdata,
  input  logic              bus_rsp_valid,
  input  logic [31:0]       bus_rdata
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  // Last WAIT_RSP cycle index before timing out, and the saturation ceiling.
  localparam logic [CntW-1:0] CntLast = (TIMEOUT_CYCLES > 0) ? CntW'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [CntW-1:0] CntSat  = (TIMEOUT_CYCLES > 0) ? CntW'(TIMEOUT_CYCLES) : '1;

  lsu_state_e        state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              req_valid_q, req_valid_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              done_q, done_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              fault_q, fault_d;
  fault_cause_e      cause_q, cause_d;

  logic [3:0]  a_wstrb;
  logic [31:0] a_wdata;
  logic [31:0] a_rdata;
  logic        a_misaligned;
  logic        a_illegal;

  // Operands are held stable by the core until mem_done, so the aligner runs off them directly.
  lsu_align u_align (
    .we         (mem_we),
    .funct3     (mem_funct3),
    .addr_lo    (mem_addr[1:0]),
    .wdata      (mem_wdata),
    .rdata      (bus_rdata),
    .wstrb      (a_wstrb),
    .wdata_rep  (a_wdata),
    .rdata_ext  (a_rdata),
    .misaligned (a_misaligned),
    .illegal    (a_illegal)
  );

  // Next-state logic; completion outputs default low so mem_done is a single-cycle pulse.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_valid_d = req_valid_q;
    addr_d      = addr_q;
    we_d        = we_q;
    wstrb_d     = wstrb_q;
    wdata_d     = wdata_q;
    done_d      = 1'b0;
    rdata_d     = '0;
    fault_d     = 1'b0;
    cause_d     = FC_NONE;
    unique case (state_q)
      IDLE: begin
        if (mem_valid) begin
          if (a_illegal) begin
            state_d = DONE;
            done_d  = 1'b1;
            fault_d = 1'b1;
            cause_d = FC_ILLEGAL;
          end else if (a_misaligned) begin
            state_d = DONE;
            done_d  = 1'b1;
            fault_d = 1'b1;
            cause_d = FC_MISALIGN;
          end else begin
            state_d     = REQ;
            req_valid_d = 1'b1;
            addr_d      = {mem_addr[ADDR_W-1:2], 2'b00};
            we_d        = mem_we;
            wstrb_d     = a_wstrb;
            wdata_d     = a_wdata;
          end
        end
      end
      REQ: begin
        if (bus_req_ready) begin
          state_d     = WAIT_RSP;
          req_valid_d = 1'b0;
          cnt_d       = '0;
        end
      end
      WAIT_RSP: begin
        if (bus_rsp_valid) begin
          state_d = DONE;
          done_d  = 1'b1;
          rdata_d = we_q ? 32'h0 : a_rdata;
        end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CntLast)) begin
          state_d = DONE;
          done_d  = 1'b1;
          fault_d = 1'b1;
          cause_d = FC_TIMEOUT;
        end else if (cnt_q != CntSat) begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      req_valid_q <= 1'b0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wstrb_q     <= 4'b0000;
      wdata_q     <= '0;
      done_q      <= 1'b0;
      rdata_q     <= '0;
      fault_q     <= 1'b0;
      cause_q     <= FC_NONE;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_valid_q <= req_valid_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wstrb_q     <= wstrb_d;
      wdata_q     <= wdata_d;
      done_q      <= done_d;
      rdata_q     <= rdata_d;
      fault_q     <= fault_d;
      cause_q     <= cause_d;
    end
  end

  assign mem_stall       = mem_valid & ~done_q;
  assign mem_done        = done_q;
  assign mem_rdata       = rdata_q;
  assign mem_fault       = fault_q;
  assign mem_fault_cause = cause_q;
  assign bus_req_valid   = req_valid_q;
  assign bus_addr        = addr_q;
  assign bus_we          = we_q;
  assign bus_wstrb       = wstrb_q;
  assign bus_wdata       = wdata_q;

endmodule
